// File: rtl/pc_gen_ras_if.sv
// Fetch PC generator bus: D-stage control in, fetch PC and RAS status out.
// The master side is the pipeline control; the slave side is pc_gen_ras.
interface pc_gen_ras_if #(
  parameter int ADDR_W    = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic              req;
  logic              stall;
  logic              eret;
  logic [ADDR_W-1:0] epc;
  logic [2:0]        pc_sel;
  logic [ADDR_W-1:0] d_pc;
  logic [31:0]       d_instr;
  logic [ADDR_W-1:0] br_offset;
  logic [ADDR_W-1:0] reg31;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  ras_count;
  logic              ras_valid;

  modport master (
    output req, stall, eret, epc, pc_sel,
    output d_pc, d_instr, br_offset, reg31,
    output ras_push, ras_pop,
    input  pc, ras_count, ras_valid
  );

  modport slave (
    input  req, stall, eret, epc, pc_sel,
    input  d_pc, d_instr, br_offset, reg31,
    input  ras_push, ras_pop,
    output pc, ras_count, ras_valid
  );
endinterface

// File: rtl/pc_gen_ras.sv
// Fetch-stage next-PC selection with a circular return-address stack.
// Priority: reset > req > stall > eret > pc_sel.
module pc_gen_ras #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] RESET_VEC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
  parameter int          RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  pc_gen_ras_if.slave     bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] SEL_SEQ = 3'b000;
  localparam logic [2:0] SEL_BR  = 3'b001;
  localparam logic [2:0] SEL_J   = 3'b010;
  localparam logic [2:0] SEL_JR  = 3'b011;
  localparam logic [2:0] SEL_RET = 3'b100;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];

  logic [PTR_W-1:0]  top_idx;
  logic [ADDR_W-1:0] top;
  logic [ADDR_W-1:0] link;
  logic              ras_nonempty;
  logic              ras_en;

  assign top_idx      = ptr_q - PTR_W'(1);
  assign top          = ras_q[top_idx];
  assign link         = bus.d_pc + ADDR_W'(8);
  assign ras_nonempty = (count_q != '0);
  assign ras_en       = !bus.req && !bus.stall && !bus.eret;

  // Next fetch PC from the highest-priority redirect source
  always_comb begin
    pc_d = pc_q;
    if (bus.req) begin
      pc_d = EXC_VEC[ADDR_W-1:0];
    end else if (bus.stall) begin
      pc_d = pc_q;
    end else if (bus.eret) begin
      pc_d = bus.epc;
    end else begin
      case (bus.pc_sel)
        SEL_SEQ: pc_d = pc_q + ADDR_W'(4);
        SEL_BR:  pc_d = bus.d_pc + ADDR_W'(4)
                      + bus.br_offset;
        SEL_J:   pc_d = {bus.d_pc[ADDR_W-1:28],
                         bus.d_instr[25:0], 2'b00};
        SEL_JR:  pc_d = bus.reg31;
        SEL_RET: pc_d = ras_nonempty ? top : bus.reg31;
        default: pc_d = pc_q;
      endcase
    end
  end

  // RAS push/pop; push+pop on a live stack rewrites the top in place
  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    ras_d   = ras_q;
    if (ras_en) begin
      if (bus.ras_push && bus.ras_pop && ras_nonempty) begin
        ras_d[top_idx] = link;
      end else if (bus.ras_push) begin
        ras_d[ptr_q] = link;
        ptr_d        = ptr_q + PTR_W'(1);
        if (count_q != CNT_FULL)
          count_d = count_q + CNT_W'(1);
      end else if (bus.ras_pop && ras_nonempty) begin
        ptr_d   = top_idx;
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // PC and stack bookkeeping registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_VEC[ADDR_W-1:0];
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  // Stack storage carries no reset value
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign bus.pc        = pc_q;
  assign bus.ras_count = count_q;
  assign bus.ras_valid = ras_nonempty;
endmodule

// File: tb/tb_pc_gen_ras.sv
// Directed checks for pc_gen_ras: selects, RAS wrap, stall/req/eret,
// push+pop, and mid-run reset.
module tb_pc_gen_ras;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  pc_gen_ras_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus ();

  pc_gen_ras #(
    .ADDR_W(32),
    .RESET_VEC(32'h0000_3000),
    .EXC_VEC(32'h0000_4180),
    .RAS_DEPTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag,
                           input logic [31:0] epc_v,
                           input int cnt);
    chk({tag, "_pc"}, bus.pc, epc_v);
    chk({tag, "_cnt"}, 32'(bus.ras_count), 32'(cnt));
    chk({tag, "_vld"}, 32'(bus.ras_valid), 32'(cnt != 0));
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    reset         = 1'b1;
    bus.req       = 1'b0;
    bus.stall     = 1'b0;
    bus.eret      = 1'b0;
    bus.epc       = '0;
    bus.pc_sel    = 3'b000;
    bus.d_pc      = '0;
    bus.d_instr   = '0;
    bus.br_offset = '0;
    bus.reg31     = '0;
    bus.ras_push  = 1'b0;
    bus.ras_pop   = 1'b0;

    // reset and sequential fetch
    step();
    chk_state("rst", 32'h3000, 0);
    reset = 1'b0;
    step(); chk("seq1", bus.pc, 32'h3004);
    step(); chk("seq2", bus.pc, 32'h3008);
    step(); chk("seq3", bus.pc, 32'h300C);

    // branch backwards and j
    bus.d_pc      = 32'h3010;
    bus.br_offset = 32'hFFFF_FFF0;
    bus.pc_sel    = 3'b001;
    step(); chk("br", bus.pc, 32'h3004);
    bus.d_instr = 32'h0000_0C10;
    bus.pc_sel  = 3'b010;
    step(); chk("j", bus.pc, 32'h3040);

    // push, return via RAS, then empty fallback
    bus.pc_sel   = 3'b000;
    bus.d_pc     = 32'h3000;
    bus.ras_push = 1'b1;
    step(); chk_state("push1", 32'h3044, 1);
    bus.ras_push = 1'b0;
    bus.ras_pop  = 1'b1;
    bus.pc_sel   = 3'b100;
    bus.reg31    = 32'h0000_DEAD;
    step(); chk_state("ret1", 32'h3008, 0);
    step(); chk_state("ret_empty", 32'hDEAD, 0);

    // jr and hold select
    bus.ras_pop = 1'b0;
    bus.pc_sel  = 3'b011;
    bus.reg31   = 32'h0000_3300;
    step(); chk("jr", bus.pc, 32'h3300);
    bus.pc_sel = 3'b110;
    step(); chk("hold", bus.pc, 32'h3300);

    // five pushes into a depth-4 stack
    bus.pc_sel   = 3'b000;
    bus.ras_push = 1'b1;
    bus.d_pc = 32'h3000; step(); chk("p1", 32'(bus.ras_count), 1);
    bus.d_pc = 32'h3004; step(); chk("p2", 32'(bus.ras_count), 2);
    bus.d_pc = 32'h3008; step(); chk("p3", 32'(bus.ras_count), 3);
    bus.d_pc = 32'h300C; step(); chk("p4", 32'(bus.ras_count), 4);
    bus.d_pc = 32'h3010; step(); chk("p5", 32'(bus.ras_count), 4);
    bus.ras_push = 1'b0;
    bus.ras_pop  = 1'b1;
    bus.pc_sel   = 3'b100;
    step(); chk_state("pop1", 32'h3018, 3);
    step(); chk_state("pop2", 32'h3014, 2);
    step(); chk_state("pop3", 32'h3010, 1);
    step(); chk_state("pop4", 32'h300C, 0);

    // stall, req over stall, eret over push
    bus.ras_pop  = 1'b0;
    bus.pc_sel   = 3'b000;
    bus.ras_push = 1'b1;
    bus.d_pc     = 32'h3000;
    step(); chk_state("pre_stall", 32'h3010, 1);
    bus.stall     = 1'b1;
    bus.pc_sel    = 3'b001;
    bus.d_pc      = 32'h3010;
    bus.br_offset = 32'h0000_0100;
    step(); chk_state("stall", 32'h3010, 1);
    bus.req = 1'b1;
    step(); chk_state("req", 32'h4180, 1);
    bus.req   = 1'b0;
    bus.stall = 1'b0;
    bus.eret  = 1'b1;
    bus.epc   = 32'h3020;
    step(); chk_state("eret", 32'h3020, 1);

    // push+pop on a two-entry stack replaces the top
    bus.eret   = 1'b0;
    bus.pc_sel = 3'b000;
    bus.d_pc   = 32'h3200;
    step(); chk_state("push2", 32'h3024, 2);
    bus.ras_pop = 1'b1;
    bus.pc_sel  = 3'b100;
    bus.d_pc    = 32'h3100;
    step(); chk_state("pushpop", 32'h3208, 2);
    bus.ras_push = 1'b0;
    step(); chk_state("top_new", 32'h3108, 1);

    // reset mid-run with a push pending
    bus.ras_push = 1'b1;
    reset        = 1'b1;
    step(); chk_state("rst2", 32'h3000, 0);

    // push+pop on an empty stack acts as a push
    reset      = 1'b0;
    bus.d_pc   = 32'h3000;
    bus.reg31  = 32'h0000_DEAD;
    step(); chk_state("pp_empty", 32'hDEAD, 1);
    bus.ras_push = 1'b0;
    step(); chk_state("pp_pop", 32'h3008, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
